led_mux: RTL and testbench

//  Time-multiplexed LED matrix row scanner. Holds NUM_ROWS column patterns and drives one row at a time.
//  o_rows carries a one-hot row strobe and o_cols carries that row's column pattern.

---
 rtl/led_mux.sv | 55 +++++
 tb/tb_led_mux.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_mux.sv
// Row scanner for a time-multiplexed LED matrix: one row strobe at a time,
// each held for CLOCK_DELAY clocks, with that row's column pattern registered alongside.
module led_mux #(
  parameter int unsigned NUM_ROWS          = 4,
  parameter int unsigned NUM_ROWS_WIDTH    = 2,
  parameter int unsigned NUM_COLS          = 8,
  parameter int unsigned CLOCK_DELAY       = 10,
  parameter int unsigned CLOCK_DELAY_WIDTH = 4
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [NUM_COLS-1:0] i_rows [0:NUM_ROWS-1],
  output logic [NUM_COLS-1:0] o_cols,
  output logic [NUM_ROWS-1:0] o_rows
);

  localparam logic [NUM_ROWS_WIDTH-1:0]    LAST_ROW = NUM_ROWS_WIDTH'(NUM_ROWS - 1);
  localparam logic [CLOCK_DELAY_WIDTH-1:0] LAST_DLY = CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1);

  logic [NUM_ROWS_WIDTH-1:0]    r_row_idx;
  logic [CLOCK_DELAY_WIDTH-1:0] r_dly_cnt;
  logic [NUM_ROWS-1:0]          w_strobe;
  logic [NUM_COLS-1:0]          w_cols;

  // Decode by search rather than direct indexing so an impossible index falls back to row 0.
  always_comb begin
    w_strobe = NUM_ROWS'(1);
    w_cols   = i_rows[0];
    for (int unsigned r = 1; r < NUM_ROWS; r++) begin
      if (r_row_idx == NUM_ROWS_WIDTH'(r)) begin
        w_strobe = NUM_ROWS'(1) << r;
        w_cols   = i_rows[r];
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_row_idx <= '0;
      r_dly_cnt <= '0;
      o_rows    <= '0;
      o_cols    <= '0;
    end else begin
      o_rows <= w_strobe;
      o_cols <= w_cols;
      if (r_dly_cnt >= LAST_DLY) begin
        r_dly_cnt <= '0;
        r_row_idx <= (r_row_idx >= LAST_ROW) ? '0 : r_row_idx + 1'b1;
      end else begin
        r_dly_cnt <= r_dly_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_mux.sv
// Directed bench for led_mux: a reference scan model pushes the expected outputs of
// each edge into a scoreboard queue, popped and compared just after that edge.
module tb_led_mux;

  localparam int unsigned NR = 4;
  localparam int unsigned NC = 8;
  localparam int unsigned CD = 10;

  typedef struct packed {
    logic [NR-1:0] rows;
    logic [NC-1:0] cols;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [NC-1:0] rows_in [0:NR-1];
  logic [NC-1:0] o_cols;
  logic [NR-1:0] o_rows;

  exp_t q[$];
  int   m_row = 0;
  int   m_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  led_mux #(
    .NUM_ROWS(NR),
    .NUM_ROWS_WIDTH(2),
    .NUM_COLS(NC),
    .CLOCK_DELAY(CD),
    .CLOCK_DELAY_WIDTH(4)
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_rows(rows_in),
    .o_cols(o_cols),
    .o_rows(o_rows)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict, let the edge happen, compare, then advance the model.
  task automatic tick(input string tag);
    exp_t e, got;
    logic rst_at_edge;
    rst_at_edge = i_rst;
    if (!rst_at_edge) e = '0;
    else begin
      e.rows = NR'(1) << m_row;
      e.cols = rows_in[m_row];
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      got = q.pop_front();
      check({tag, "_rows"}, 16'(o_rows), 16'(got.rows));
      check({tag, "_cols"}, 16'(o_cols), 16'(got.cols));
      if (rst_at_edge) check({tag, "_onehot"}, 16'($onehot(o_rows)), 16'd1);
    end
    if (rst_at_edge) begin
      if (m_cnt == CD - 1) begin
        m_cnt = 0;
        m_row = (m_row == NR - 1) ? 0 : m_row + 1;
      end else m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_row = 0;
    m_cnt = 0;
    q.delete();
  endtask

  initial begin
    rows_in[0] = 8'h0F;
    rows_in[1] = 8'hF0;
    rows_in[2] = 8'hCC;
    rows_in[3] = 8'hAA;

    // Async reset with no clock edge in between.
    #2 i_rst = 1'b0;
    #1;
    check("rst_async_rows", 16'(o_rows), 16'h0);
    check("rst_async_cols", 16'(o_cols), 16'h00);
    model_reset();
    @(posedge clk); #1;
    tick("rst_held");
    tick("rst_held");

    // Release and run a full frame plus the wrap edge.
    i_rst = 1'b1;
    for (int i = 1; i <= 41; i++) begin
      tick("frame1");
      if (i == 1)  check("edge1_rows",  16'(o_rows), 16'h1);
      if (i == 10) check("edge10_cols", 16'(o_cols), 16'h0F);
      if (i == 11) check("edge11_rows", 16'(o_rows), 16'h2);
      if (i == 21) check("edge21_cols", 16'(o_cols), 16'hCC);
      if (i == 40) check("edge40_rows", 16'(o_rows), 16'h8);
      if (i == 41) check("edge41_wrap", 16'(o_rows), 16'h1);
    end

    // Column data change mid-dwell of row 0 shows up on the next edge.
    repeat (3) tick("pre_chg");
    rows_in[0] = 8'h55;
    tick("chg");
    check("chg_cols", 16'(o_cols), 16'h55);
    check("chg_rows", 16'(o_rows), 16'h1);

    // Run into row 2, then reset mid-dwell.
    while (!(m_row == 2 && m_cnt == 4)) tick("to_row2");
    check("row2_rows", 16'(o_rows), 16'h4);
    i_rst = 1'b0;
    #1;
    check("midrst_rows", 16'(o_rows), 16'h0);
    check("midrst_cols", 16'(o_cols), 16'h00);
    model_reset();
    @(negedge clk);
    tick("midrst_held");
    i_rst = 1'b1;

    // Full dwell on row 0 after release, then three frames with varying data.
    for (int i = 1; i <= CD + 1; i++) begin
      tick("restart");
      if (i == CD)     check("restart_last_row0", 16'(o_rows), 16'h1);
      if (i == CD + 1) check("restart_row1",      16'(o_rows), 16'h2);
    end
    for (int i = 0; i < 3 * NR * CD; i++) begin
      if (i % 7 == 3) rows_in[$urandom_range(NR - 1)] = NC'($urandom);
      tick("frames3");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
